// File: rtl/instr_queue.sv
// instr_queue
//   Circular instruction queue with valid/ready handshakes on both sides.
//   The head entry is split into an opcode field (MSBs) and an operand field
//   (LSBs). Both fields read 0 while the queue is empty.
//
// Parameters
//   INST_W  instruction width (>= 2)
//   OPC_W   opcode width, taken from the MSBs (1 <= OPC_W < INST_W)
//   DEPTH   number of entries (power of two, >= 2)
//
// Ports
//   iq_clk        clock, rising edge
//   iq_rst_n      synchronous active-low reset (clears pointers and count)
//   iq_flush      synchronous discard of all entries; overrides push and pop
//   iq_in_valid   producer offers iq_inst
//   iq_in_ready   queue can accept (not full)
//   iq_inst       instruction to enqueue
//   iq_out_valid  head entry valid (not empty)
//   iq_out_ready  consumer takes the head entry
//   iq_opcode     head instruction opcode field
//   iq_operand    head instruction operand field
//   iq_count      occupied entries
//   iq_full       count == DEPTH
//   iq_empty      count == 0
//   iq_err        (only with IQ_ERR_FLAG_EN) sticky flag: push while full or
//                 pop while empty was attempted; cleared by reset or flush
//
// Build option
//   IQ_ERR_FLAG_EN  adds the iq_err output and its sticky error logic.

module instr_queue #(
  parameter int INST_W = 8,
  parameter int OPC_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                         iq_clk,
  input  logic                         iq_rst_n,
  input  logic                         iq_flush,
  input  logic                         iq_in_valid,
  output logic                         iq_in_ready,
  input  logic [INST_W-1:0]            iq_inst,
  output logic                         iq_out_valid,
  input  logic                         iq_out_ready,
  output logic [OPC_W-1:0]             iq_opcode,
  output logic [INST_W-OPC_W-1:0]      iq_operand,
  output logic [$clog2(DEPTH+1)-1:0]   iq_count,
  output logic                         iq_full,
`ifdef IQ_ERR_FLAG_EN
  output logic                         iq_empty,
  output logic                         iq_err
`else
  output logic                         iq_empty
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Elaboration-time parameter legality checks
  if (INST_W < 2) begin : g_bad_inst_w
    $error("instr_queue: INST_W must be at least 2");
  end
  if (OPC_W < 1 || OPC_W >= INST_W) begin : g_bad_opc_w
    $error("instr_queue: OPC_W must satisfy 1 <= OPC_W < INST_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_queue: DEPTH must be a power of two, at least 2");
  end

  logic [INST_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [INST_W-1:0] head_inst;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // in_ready depends only on the current count, so a pop in the same cycle
  // never opens the full queue to a push.
  assign push = iq_in_valid && !full;
  assign pop  = iq_out_ready && !empty;

  always_ff @(posedge iq_clk) begin
    if (!iq_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (iq_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // DEPTH is a power of two, so the natural pointer overflow is the
      // modulo-DEPTH wrap.
      if (push) tail_q <= tail_q + PTR_ONE;
      if (pop)  head_q <= head_q + PTR_ONE;
      if (push && !pop)
        count_q <= count_q + CNT_ONE;
      else if (pop && !push)
        count_q <= count_q - CNT_ONE;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge iq_clk) begin
    if (iq_rst_n && !iq_flush && push)
      mem[tail_q] <= iq_inst;
  end

  assign head_inst = mem[head_q];

  always_comb begin
    iq_opcode  = '0;
    iq_operand = '0;
    if (!empty) begin
      iq_opcode  = head_inst[INST_W-1 -: OPC_W];
      iq_operand = head_inst[INST_W-OPC_W-1:0];
    end
  end

  assign iq_in_ready  = !full;
  assign iq_out_valid = !empty;
  assign iq_full      = full;
  assign iq_empty     = empty;
  assign iq_count     = count_q;

`ifdef IQ_ERR_FLAG_EN
  logic err_q;

  always_ff @(posedge iq_clk) begin
    if (!iq_rst_n) begin
      err_q <= 1'b0;
    end else if (iq_flush) begin
      err_q <= 1'b0;
    end else if ((iq_in_valid && full) || (iq_out_ready && empty)) begin
      err_q <= 1'b1;
    end
  end

  assign iq_err = err_q;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue
//   Self-checking bench for instr_queue (INST_W=8, OPC_W=4, DEPTH=4).
//   A queue of expected instructions is filled when pushes are driven and
//   drained when pops are driven; head, count and flags are compared against
//   it after every edge.

module tb_instr_queue;

  localparam int INST_W = 8;
  localparam int OPC_W  = 4;
  localparam int DEPTH  = 4;

  logic       clk_tb;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] inst;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic [2:0] count;
  logic       full;
  logic       empty;
`ifdef IQ_ERR_FLAG_EN
  logic       err;
`endif

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb[$];
  logic       exp_err;

  instr_queue #(
    .INST_W (INST_W),
    .OPC_W  (OPC_W),
    .DEPTH  (DEPTH)
  ) dut (
    .iq_clk       (clk_tb),
    .iq_rst_n     (rst_n),
    .iq_flush     (flush),
    .iq_in_valid  (in_valid),
    .iq_in_ready  (in_ready),
    .iq_inst      (inst),
    .iq_out_valid (out_valid),
    .iq_out_ready (out_ready),
    .iq_opcode    (opcode),
    .iq_operand   (operand),
    .iq_count     (count),
    .iq_full      (full),
`ifdef IQ_ERR_FLAG_EN
    .iq_empty     (empty),
    .iq_err       (err)
`else
    .iq_empty     (empty)
`endif
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  // Drive one cycle of stimulus, update the scoreboard at the edge, and
  // return 1 time unit after the edge so outputs can be sampled.
  task automatic drive(input logic v, input logic [7:0] d, input logic r,
                       input logic f);
    bit do_push;
    bit do_pop;
    in_valid  = v;
    inst      = d;
    out_ready = r;
    flush     = f;
    @(posedge clk_tb);
    if (!rst_n) begin
      sb.delete();
      exp_err = 1'b0;
    end else if (f) begin
      sb.delete();
      exp_err = 1'b0;
    end else begin
      if ((v && sb.size() == DEPTH) || (r && sb.size() == 0)) exp_err = 1'b1;
      do_push = v && (sb.size() < DEPTH);
      do_pop  = r && (sb.size() > 0);
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(d);
    end
    #1;
  endtask

  function automatic logic [7:0] exp_head();
    return (sb.size() > 0) ? sb[0] : 8'h00;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (count !== 3'd0) begin failures++;
      $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({empty, full} !== 2'b10) begin failures++;
      $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); end
    checks++; if ({opcode, operand} !== 8'h00) begin failures++;
      $display("FAIL reset_head got=%h exp=00", {opcode, operand}); end
`ifdef IQ_ERR_FLAG_EN
    checks++; if (err !== 1'b0) begin failures++;
      $display("FAIL reset_err got=%b exp=0", err); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_load_hold();
    drive(1'b1, 8'h12, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1 || {opcode, operand} !== exp_head()) begin failures++;
      $display("FAIL load_head got valid=%b head=%h exp valid=1 head=%h",
               out_valid, {opcode, operand}, exp_head()); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h4C, 1'b0, 1'b0);
      checks++; if (opcode !== 4'h1 || operand !== 4'h2) begin failures++;
        $display("FAIL hold_%0d got op=%h opd=%h exp op=1 opd=2", i, opcode, operand); end
    end
    checks++; if (count !== 3'(sb.size())) begin failures++;
      $display("FAIL hold_count got=%0d exp=%0d", count, sb.size()); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1 || {opcode, operand} !== 8'h00) begin failures++;
      $display("FAIL load_drain got empty=%b head=%h exp empty=1 head=00",
               empty, {opcode, operand}); end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] vals[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vals[i], 1'b0, 1'b0);
      checks++; if (count !== 3'(sb.size())) begin failures++;
        $display("FAIL fill_count_%0d got=%0d exp=%0d", i, count, sb.size()); end
    end
    checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin failures++;
      $display("FAIL overflow got full=%b in_ready=%b count=%0d exp full=1 in_ready=0 count=4",
               full, in_ready, count); end
    checks++; if ({opcode, operand} !== 8'h11) begin failures++;
      $display("FAIL overflow_head got=%h exp=11", {opcode, operand}); end
`ifdef IQ_ERR_FLAG_EN
    checks++; if (err !== exp_err || exp_err !== 1'b1) begin failures++;
      $display("FAIL overflow_err got=%b exp=1", err); end
`endif
  endtask

  task automatic test_drain_wrap();
    logic [7:0] order[4] = '{8'h33, 8'h44, 8'hA1, 8'hB2};
    logic [7:0] got;
    for (int i = 0; i < 2; i++) begin
      got = {opcode, operand};
      checks++; if (got !== exp_head()) begin failures++;
        $display("FAIL drain_pre_%0d got=%h exp=%h", i, got, exp_head()); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    checks++; if (count !== 3'd4) begin failures++;
      $display("FAIL wrap_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      got = {opcode, operand};
      checks++; if (got !== exp_head() || got !== order[i]) begin failures++;
        $display("FAIL wrap_order_%0d got=%h exp=%h", i, got, order[i]); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin failures++;
      $display("FAIL wrap_empty got empty=%b valid=%b exp empty=1 valid=0", empty, out_valid); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (count !== 3'd0 || {opcode, operand} !== 8'h00) begin failures++;
      $display("FAIL underflow got count=%0d head=%h exp count=0 head=00", count, {opcode, operand}); end
`ifdef IQ_ERR_FLAG_EN
    checks++; if (err !== exp_err) begin failures++;
      $display("FAIL underflow_err got=%b exp=%b", err, exp_err); end
`endif
  endtask

  task automatic test_simul_push_pop();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
`ifdef IQ_ERR_FLAG_EN
    checks++; if (err !== 1'b0) begin failures++;
      $display("FAIL flush_err_clear got=%b exp=0", err); end
`endif
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    // Full: a pop in the same cycle must not let the push through.
    drive(1'b1, 8'h66, 1'b1, 1'b0);
    checks++; if (count !== 3'd3 || count !== 3'(sb.size())) begin failures++;
      $display("FAIL full_no_passthru got count=%0d exp=%0d", count, sb.size()); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (count !== 3'd2 || {opcode, operand} !== 8'h03) begin failures++;
      $display("FAIL pre_simul got count=%0d head=%h exp count=2 head=03", count, {opcode, operand}); end
    drive(1'b1, 8'h05, 1'b1, 1'b0);
    checks++; if (count !== 3'd2 || {opcode, operand} !== exp_head()) begin failures++;
      $display("FAIL simul got count=%0d head=%h exp count=2 head=%h",
               count, {opcode, operand}, exp_head()); end
    while (sb.size() > 0) begin
      checks++; if ({opcode, operand} !== exp_head()) begin failures++;
        $display("FAIL simul_drain got=%h exp=%h", {opcode, operand}, exp_head()); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) begin failures++;
      $display("FAIL simul_empty got=%b exp=1", empty); end
  endtask

  task automatic test_flush();
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    drive(1'b1, 8'h88, 1'b0, 1'b0);
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin failures++;
      $display("FAIL flush_push got count=%0d empty=%b exp count=0 empty=1", count, empty); end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0 || {opcode, operand} !== 8'h00) begin failures++;
      $display("FAIL flush_lost got valid=%b head=%h exp valid=0 head=00", out_valid, {opcode, operand}); end
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    checks++; if ({opcode, operand} !== 8'hC3 || count !== 3'd1) begin failures++;
      $display("FAIL post_flush got head=%h count=%0d exp head=c3 count=1", {opcode, operand}, count); end
  endtask

  task automatic test_reset_mid_op();
    drive(1'b1, 8'hD4, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 8'hE5, 1'b1, 1'b1);
    rst_n = 1'b1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
      $display("FAIL reset_mid got count=%0d valid=%b ready=%b exp count=0 valid=0 ready=1",
               count, out_valid, in_ready); end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (empty !== 1'b1 || {opcode, operand} !== 8'h00) begin failures++;
      $display("FAIL reset_mid_idle got empty=%b head=%h exp empty=1 head=00", empty, {opcode, operand}); end
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inst      = '0;
    exp_err   = 1'b0;
    test_reset();
    test_load_hold();
    test_fill_overflow();
    test_drain_wrap();
    test_simul_push_pop();
    test_flush();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter INST_W, default 8: instruction width in bits; SHALL be at least 2.
REQ-002 Parameter OPC_W, default 4: opcode field width, taken from the MSBs; SHALL satisfy 1 <= OPC_W < INST_W.
REQ-003 Parameter DEPTH, default 4: number of entries; SHALL be a power of two, at least 2.
REQ-004 iq_clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 iq_rst_n  input  1  reset, synchronous and active-low.
REQ-006 iq_flush  input  1  synchronous discard of all queued instructions.
REQ-007 iq_in_valid  input  1  producer offers iq_inst this cycle.
REQ-008 iq_in_ready  output  1  queue can accept; equals !iq_full.
REQ-009 iq_inst  input  INST_W  instruction to enqueue.
REQ-010 iq_out_valid  output  1  head entry is valid; equals !iq_empty.
REQ-011 iq_out_ready  input  1  consumer accepts the head entry this cycle.
REQ-012 iq_opcode  output  OPC_W  head instruction bits [INST_W-1 : INST_W-OPC_W].
REQ-013 iq_operand  output  INST_W-OPC_W  head instruction bits [INST_W-OPC_W-1 : 0].
REQ-014 iq_count  output  clog2(DEPTH+1)  number of occupied entries.
REQ-015 iq_full / iq_empty  output  1 each  count==DEPTH / count==0.

Function
REQ-016 Push SHALL occur when iq_in_valid && iq_in_ready at a rising edge; iq_inst is written at the tail and the tail pointer advances modulo DEPTH.
REQ-017 Pop SHALL occur when iq_out_valid && iq_out_ready at a rising edge; the head pointer advances modulo DEPTH.
REQ-018 Latency: an instruction pushed at edge N SHALL appear on iq_opcode/iq_operand with iq_out_valid=1 from edge N onward when the queue was empty, with no same-cycle input-to-output bypass.
REQ-019 Simultaneous push and pop on a non-empty, non-full queue SHALL leave iq_count unchanged; both pointers advance.
REQ-020 When full, iq_in_ready SHALL be 0 even if a pop occurs in the same cycle; there is no full-state pass-through.
REQ-021 A push offered while full and a pop requested while empty SHALL be ignored with no state change.
REQ-022 When empty, iq_opcode and iq_operand SHALL be driven to 0.
REQ-023 Head outputs SHALL hold their values while iq_out_ready=0, regardless of iq_inst activity; this is the hold behaviour.
REQ-024 Pointer wrap-around SHALL be seamless; FIFO order is preserved across the DEPTH-1 to 0 boundary.
REQ-025 iq_flush=1 SHALL set count and both pointers to 0 at the next edge, overriding any push or pop in the same cycle.

Reset
REQ-026 iq_rst_n=0 at a rising edge SHALL clear both pointers and iq_count; iq_out_valid=0, iq_in_ready=1, iq_empty=1, iq_full=0, and iq_opcode=iq_operand=0.
REQ-027 Reset SHALL take priority over flush, push and pop.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; storage contents need not be cleared.

Configuration
REQ-029 When macro IQ_ERR_FLAG_EN is defined, an extra output iq_err (1 bit) SHALL exist.
REQ-030 iq_err SHALL set at the edge following a push attempt while full or a pop attempt while empty, and SHALL remain set (sticky) until reset or flush.
REQ-031 When IQ_ERR_FLAG_EN is undefined, the iq_err port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (INST_W=8, OPC_W=4, DEPTH=4)
REQ-032 Reset: hold iq_rst_n=0 for 2 edges -> count=0, out_valid=0, in_ready=1, opcode=0, operand=0.
REQ-033 Single load and hold: push 8'h12, out_ready=0, then drive iq_inst=8'h4C with in_valid=0 -> opcode=4'h1 and operand=4'h2 persist for 3 edges.
REQ-034 Fill and overflow: push 8'h11, 8'h22, 8'h33, 8'h44, then 8'h55 -> full=1, in_ready=0, count=4, 8'h55 dropped; iq_err=1 if IQ_ERR_FLAG_EN is defined.
REQ-035 Drain with wrap-around: pop 2, push 8'hA1 and 8'hB2, then pop all -> output order 33, 44, A1, B2, ending with empty=1.
REQ-036 Simultaneous push/pop at count=2 -> count stays 2 and head advances; flush asserted together with push -> count=0 next edge and the pushed item is lost.
